// File: rtl/mem_port_arbiter_if.sv
// Bundle of the pipeline request ports and the RAM port around mem_port_arbiter.
// The arbiter uses the slave view; the surrounding pipeline/RAM model uses master.
interface mem_port_arbiter_if;
   // Fetch port
   logic        if_request;
   logic [31:0] if_address;
   logic        if_ready;
   logic [31:0] if_instruction;
   // Data port
   logic        mem_request;
   logic        mem_write;
   logic [31:0] mem_address;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   // RAM port
   logic        ram_enable;
   logic        ram_write;
   logic [31:0] ram_address;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;
   // Pipeline hold
   logic        stall;

   modport slave (
      input  if_request, if_address,
      output if_ready, if_instruction,
      input  mem_request, mem_write, mem_address, mem_wdata,
      output mem_ready, mem_rdata,
      output ram_enable, ram_write, ram_address, ram_wdata,
      input  ram_rdata,
      output stall
   );

   modport master (
      output if_request, if_address,
      input  if_ready, if_instruction,
      output mem_request, mem_write, mem_address, mem_wdata,
      input  mem_ready, mem_rdata,
      input  ram_enable, ram_write, ram_address, ram_wdata,
      output ram_rdata,
      input  stall
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port RAM between the fetch and data ports of the pipeline,
// one access at a time, returning results on a one-cycle ready pulse and driving the pipeline stall.
module mem_port_arbiter #(
   parameter int LATENCY     = 2,
   parameter bit ROUND_ROBIN = 1'b1
) (
   input  logic                   clock,
   input  logic                   reset,
   mem_port_arbiter_if.slave      bus,
   output logic [1:0]             dbg_state_o
);

   // Handshake: a requester raises its request with stable fields and holds them until its
   // ready pulse; ready is high for exactly one cycle, and a request still high in that
   // cycle is not eligible, so the requester has one cycle to drop it or present a new one.

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;

   localparam logic PORT_FETCH = 1'b0;
   localparam logic PORT_DATA  = 1'b1;

   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   logic [1:0]  state_q,     state_d;
   logic        next_q,      next_d;
   logic [3:0]  cnt_q,       cnt_d;
   logic [31:0] addr_q,      addr_d;
   logic        wr_q,        wr_d;
   logic [31:0] wdata_q,     wdata_d;
   logic        if_ready_q,  if_ready_d;
   logic        mem_ready_q, mem_ready_d;
   logic [31:0] if_instr_q,  if_instr_d;
   logic [31:0] mem_rdata_q, mem_rdata_d;

   logic if_elig;
   logic mem_elig;
   logic grant_data;
   logic grant_fetch;
   logic busy;

   // A port in its own ready cycle is masked so a held request is not re-granted.
   assign if_elig  = bus.if_request  & ~if_ready_q;
   assign mem_elig = bus.mem_request & ~mem_ready_q;

   always_comb begin
      state_d     = state_q;
      next_d      = next_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      wr_d        = wr_q;
      wdata_d     = wdata_q;
      if_ready_d  = 1'b0;
      mem_ready_d = 1'b0;
      if_instr_d  = if_instr_q;
      mem_rdata_d = mem_rdata_q;
      grant_data  = 1'b0;
      grant_fetch = 1'b0;

      case (state_q)
         S_IDLE: begin
            // next_q names the port that wins the next tie; it starts out as the data port.
            grant_data  = mem_elig & (~if_elig | (ROUND_ROBIN == 1'b0) | (next_q == PORT_DATA));
            grant_fetch = if_elig & ~grant_data;
            if (grant_data) begin
               state_d = S_DATA;
               addr_d  = bus.mem_address;
               wr_d    = bus.mem_write;
               wdata_d = bus.mem_wdata;
               cnt_d   = CNT_INIT;
               next_d  = PORT_FETCH;
            end else if (grant_fetch) begin
               state_d = S_FETCH;
               addr_d  = bus.if_address;
               wr_d    = 1'b0;
               wdata_d = 32'h0;
               cnt_d   = CNT_INIT;
               next_d  = PORT_DATA;
            end
         end
         S_FETCH: begin
            if (cnt_q == 4'd0) begin
               state_d = S_IDLE;
               // A fetch flushed mid-access completes silently and keeps the old instruction.
               if (bus.if_request) begin
                  if_ready_d = 1'b1;
                  if_instr_d = bus.ram_rdata;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_DATA: begin
            if (cnt_q == 4'd0) begin
               state_d     = S_IDLE;
               mem_ready_d = bus.mem_request;
               if (bus.mem_request && !wr_q) begin
                  mem_rdata_d = bus.ram_rdata;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         next_q      <= PORT_DATA;
         cnt_q       <= 4'd0;
         addr_q      <= 32'h0;
         wr_q        <= 1'b0;
         wdata_q     <= 32'h0;
         if_ready_q  <= 1'b0;
         mem_ready_q <= 1'b0;
         if_instr_q  <= 32'h0;
         mem_rdata_q <= 32'h0;
      end else begin
         state_q     <= state_d;
         next_q      <= next_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         wr_q        <= wr_d;
         wdata_q     <= wdata_d;
         if_ready_q  <= if_ready_d;
         mem_ready_q <= mem_ready_d;
         if_instr_q  <= if_instr_d;
         mem_rdata_q <= mem_rdata_d;
      end
   end

   assign busy = (state_q != S_IDLE);

   // RAM strobes come straight from state so an asynchronous reset kills them at once.
   assign bus.ram_enable  = busy;
   assign bus.ram_write   = (state_q == S_DATA) & wr_q;
   assign bus.ram_address = busy ? addr_q  : 32'h0;
   assign bus.ram_wdata   = busy ? wdata_q : 32'h0;

   assign bus.if_ready       = if_ready_q;
   assign bus.if_instruction = if_instr_q;
   assign bus.mem_ready      = mem_ready_q;
   assign bus.mem_rdata      = mem_rdata_q;

   assign bus.stall = (bus.if_request & ~if_ready_q) | (bus.mem_request & ~mem_ready_q);

   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: RAM model, per-scenario tasks and a ready-driven scoreboard.
module tb_mem_port_arbiter;

   localparam int LAT = 2;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;

   logic        clk;
   logic        rst_n;
   logic [1:0]  dbg_state;
   logic [31:0] ram_mem [0:255];

   logic [31:0] exp_if_q[$];
   logic [31:0] exp_mem_q[$];

   int          total;
   int          bad;
   logic [31:0] last_instr;
   logic [31:0] last_rdata;
   logic [31:0] exp_v;

   mem_port_arbiter_if bus ();

   mem_port_arbiter #(
      .LATENCY     (LAT),
      .ROUND_ROBIN (1'b1)
   ) dut (
      .clock       (clk),
      .reset       (rst_n),
      .bus         (bus),
      .dbg_state_o (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- RAM model ----------------
   function automatic logic [31:0] init_word(input logic [31:0] addr);
      case (addr)
         32'h0000_0040: init_word = 32'h8C22_0004;
         32'h0000_0100: init_word = 32'h1234_5678;
         default:       init_word = addr ^ 32'h5A5A_0000;
      endcase
   endfunction

   assign bus.ram_rdata = bus.ram_enable ? ram_mem[bus.ram_address[9:2]] : 32'h0;

   initial begin
      for (int i = 0; i < 256; i++) ram_mem[i] = init_word(32'(i) << 2);
      forever begin
         @(posedge clk);
         if (bus.ram_enable === 1'b1 && bus.ram_write === 1'b1)
            ram_mem[bus.ram_address[9:2]] = bus.ram_wdata;
      end
   end

   // ---------------- driver helpers ----------------
   task automatic drive_idle();
      bus.if_request  = 1'b0;
      bus.if_address  = 32'h0;
      bus.mem_request = 1'b0;
      bus.mem_write   = 1'b0;
      bus.mem_address = 32'h0;
      bus.mem_wdata   = 32'h0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      drive_idle();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if ({bus.ram_enable, bus.ram_write, bus.if_ready, bus.mem_ready, bus.stall} !== 5'b0) begin
         bad++; $display("FAIL reset_ctrl: got %b want 00000",
                         {bus.ram_enable, bus.ram_write, bus.if_ready, bus.mem_ready, bus.stall});
      end
      total++;
      if (bus.if_instruction !== 32'h0 || bus.mem_rdata !== 32'h0) begin
         bad++; $display("FAIL reset_data: got %h/%h want 0/0", bus.if_instruction, bus.mem_rdata);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (dbg_state !== ST_IDLE || bus.ram_address !== 32'h0) begin
         bad++; $display("FAIL reset_idle: state %0d addr %h want 0 0", dbg_state, bus.ram_address);
      end
      last_instr = 32'h0;
      last_rdata = 32'h0;
   endtask

   task automatic test_single_fetch();
      @(posedge clk); #1;
      bus.if_request = 1'b1;
      bus.if_address = 32'h0000_0040;
      exp_if_q.push_back(init_word(32'h0000_0040));
      for (int c = 0; c <= LAT + 1; c++) begin
         @(negedge clk);
         total++;
         if (bus.ram_enable !== (c >= 1 && c <= LAT)) begin
            bad++; $display("FAIL sf_enable c%0d: got %b want %b", c, bus.ram_enable, (c >= 1 && c <= LAT));
         end
         total++;
         if (bus.stall !== (c <= LAT)) begin
            bad++; $display("FAIL sf_stall c%0d: got %b want %b", c, bus.stall, (c <= LAT));
         end
         total++;
         if (bus.if_ready !== (c == LAT + 1)) begin
            bad++; $display("FAIL sf_ready c%0d: got %b want %b", c, bus.if_ready, (c == LAT + 1));
         end
         if (c == 1) begin
            total++;
            if (bus.ram_address !== 32'h0000_0040) begin
               bad++; $display("FAIL sf_addr: got %h want 00000040", bus.ram_address);
            end
         end
         if (bus.if_ready === 1'b1) begin
            total++;
            if (exp_if_q.size() == 0) begin
               bad++; $display("FAIL sf_sb: unexpected if_ready");
            end else begin
               exp_v = exp_if_q.pop_front();
               if (bus.if_instruction !== exp_v) begin
                  bad++; $display("FAIL sf_data: got %h want %h", bus.if_instruction, exp_v);
               end
               last_instr = exp_v;
            end
         end
      end
      @(posedge clk); #1;
      bus.if_request = 1'b0;
   endtask

   task automatic test_simultaneous();
      @(posedge clk); #1;
      bus.if_request  = 1'b1;
      bus.if_address  = 32'h0000_0044;
      bus.mem_request = 1'b1;
      bus.mem_write   = 1'b0;
      bus.mem_address = 32'h0000_0100;
      exp_mem_q.push_back(init_word(32'h0000_0100));
      exp_if_q.push_back(init_word(32'h0000_0044));
      for (int c = 0; c <= 2 * LAT + 2; c++) begin
         @(negedge clk);
         total++;
         if (bus.ram_enable !== ((c >= 1 && c <= LAT) || (c >= LAT + 2 && c <= 2 * LAT + 1))) begin
            bad++; $display("FAIL sim_enable c%0d: got %b", c, bus.ram_enable);
         end
         total++;
         if (bus.mem_ready !== (c == LAT + 1) || bus.if_ready !== (c == 2 * LAT + 2)) begin
            bad++; $display("FAIL sim_ready c%0d: got mem %b if %b", c, bus.mem_ready, bus.if_ready);
         end
         total++;
         if (bus.stall !== (c <= 2 * LAT + 1)) begin
            bad++; $display("FAIL sim_stall c%0d: got %b want %b", c, bus.stall, (c <= 2 * LAT + 1));
         end
         if (bus.mem_ready === 1'b1) begin
            total++;
            if (exp_mem_q.size() == 0) begin
               bad++; $display("FAIL sim_sb_mem: unexpected mem_ready");
            end else begin
               exp_v = exp_mem_q.pop_front();
               if (bus.mem_rdata !== exp_v) begin
                  bad++; $display("FAIL sim_mem_data: got %h want %h", bus.mem_rdata, exp_v);
               end
               last_rdata = exp_v;
            end
         end
         if (bus.if_ready === 1'b1) begin
            total++;
            if (exp_if_q.size() == 0) begin
               bad++; $display("FAIL sim_sb_if: unexpected if_ready");
            end else begin
               exp_v = exp_if_q.pop_front();
               if (bus.if_instruction !== exp_v) begin
                  bad++; $display("FAIL sim_if_data: got %h want %h", bus.if_instruction, exp_v);
               end
               last_instr = exp_v;
            end
         end
         if (c == LAT + 1) begin
            @(posedge clk); #1;
            bus.mem_request = 1'b0;
         end
      end
      @(posedge clk); #1;
      bus.if_request = 1'b0;
   endtask

   task automatic test_round_robin();
      @(posedge clk); #1;
      bus.if_request  = 1'b1;
      bus.if_address  = 32'h0000_0048;
      bus.mem_request = 1'b1;
      bus.mem_write   = 1'b0;
      bus.mem_address = 32'h0000_0104;
      exp_mem_q.push_back(init_word(32'h0000_0104));
      exp_if_q.push_back(init_word(32'h0000_0048));
      exp_mem_q.push_back(init_word(32'h0000_0104));
      for (int c = 0; c <= 3 * LAT + 4; c++) begin
         @(negedge clk);
         total++;
         if (bus.mem_ready !== (c == LAT + 1 || c == 3 * LAT + 3) || bus.if_ready !== (c == 2 * LAT + 2)) begin
            bad++; $display("FAIL rr_ready c%0d: got mem %b if %b", c, bus.mem_ready, bus.if_ready);
         end
         if (c == LAT + 2) begin
            total++;
            if (dbg_state !== ST_FETCH || bus.ram_address !== 32'h0000_0048) begin
               bad++; $display("FAIL rr_second_grant: got state %0d addr %h want 1 00000048", dbg_state, bus.ram_address);
            end
         end
         if (c == 2 * LAT + 3) begin
            total++;
            if (dbg_state !== ST_DATA) begin
               bad++; $display("FAIL rr_third_grant: got state %0d want 2", dbg_state);
            end
         end
         if (c == 3 * LAT + 4) begin
            total++;
            if (dbg_state !== ST_IDLE || bus.ram_enable !== 1'b0) begin
               bad++; $display("FAIL rr_final_idle: got state %0d en %b", dbg_state, bus.ram_enable);
            end
         end
         if (bus.mem_ready === 1'b1) begin
            total++;
            if (exp_mem_q.size() == 0) begin
               bad++; $display("FAIL rr_sb_mem: unexpected mem_ready");
            end else begin
               exp_v = exp_mem_q.pop_front();
               if (bus.mem_rdata !== exp_v) begin
                  bad++; $display("FAIL rr_mem_data: got %h want %h", bus.mem_rdata, exp_v);
               end
               last_rdata = exp_v;
            end
         end
         if (bus.if_ready === 1'b1) begin
            total++;
            if (exp_if_q.size() == 0) begin
               bad++; $display("FAIL rr_sb_if: unexpected if_ready");
            end else begin
               exp_v = exp_if_q.pop_front();
               if (bus.if_instruction !== exp_v) begin
                  bad++; $display("FAIL rr_if_data: got %h want %h", bus.if_instruction, exp_v);
               end
               last_instr = exp_v;
            end
         end
         if (c == 2 * LAT + 2) begin
            @(posedge clk); #1;
            bus.if_request = 1'b0;
         end
         if (c == 3 * LAT + 3) begin
            @(posedge clk); #1;
            bus.mem_request = 1'b0;
         end
      end
   endtask

   // Last grant above went to the data port, so a fresh tie must go to fetch.
   task automatic test_tie_fetch_first();
      @(posedge clk); #1;
      bus.if_request  = 1'b1;
      bus.if_address  = 32'h0000_004C;
      bus.mem_request = 1'b1;
      bus.mem_write   = 1'b0;
      bus.mem_address = 32'h0000_0108;
      exp_if_q.push_back(init_word(32'h0000_004C));
      exp_mem_q.push_back(init_word(32'h0000_0108));
      for (int c = 0; c <= 2 * LAT + 2; c++) begin
         @(negedge clk);
         total++;
         if (bus.if_ready !== (c == LAT + 1) || bus.mem_ready !== (c == 2 * LAT + 2)) begin
            bad++; $display("FAIL tie_ready c%0d: got if %b mem %b", c, bus.if_ready, bus.mem_ready);
         end
         if (bus.if_ready === 1'b1) begin
            total++;
            if (exp_if_q.size() == 0) begin
               bad++; $display("FAIL tie_sb_if: unexpected if_ready");
            end else begin
               exp_v = exp_if_q.pop_front();
               if (bus.if_instruction !== exp_v) begin
                  bad++; $display("FAIL tie_if_data: got %h want %h", bus.if_instruction, exp_v);
               end
               last_instr = exp_v;
            end
         end
         if (bus.mem_ready === 1'b1) begin
            total++;
            if (exp_mem_q.size() == 0) begin
               bad++; $display("FAIL tie_sb_mem: unexpected mem_ready");
            end else begin
               exp_v = exp_mem_q.pop_front();
               if (bus.mem_rdata !== exp_v) begin
                  bad++; $display("FAIL tie_mem_data: got %h want %h", bus.mem_rdata, exp_v);
               end
               last_rdata = exp_v;
            end
         end
         if (c == LAT + 1) begin
            @(posedge clk); #1;
            bus.if_request = 1'b0;
         end
      end
      @(posedge clk); #1;
      bus.mem_request = 1'b0;
   endtask

   task automatic test_store();
      @(posedge clk); #1;
      bus.mem_request = 1'b1;
      bus.mem_write   = 1'b1;
      bus.mem_address = 32'h0000_0200;
      bus.mem_wdata   = 32'hDEAD_BEEF;
      for (int c = 0; c <= LAT + 1; c++) begin
         @(negedge clk);
         total++;
         if (bus.ram_write !== (c >= 1 && c <= LAT)) begin
            bad++; $display("FAIL st_write c%0d: got %b want %b", c, bus.ram_write, (c >= 1 && c <= LAT));
         end
         total++;
         if (bus.ram_wdata !== ((c >= 1 && c <= LAT) ? 32'hDEAD_BEEF : 32'h0)) begin
            bad++; $display("FAIL st_wdata c%0d: got %h", c, bus.ram_wdata);
         end
         total++;
         if (bus.mem_ready !== (c == LAT + 1)) begin
            bad++; $display("FAIL st_ready c%0d: got %b want %b", c, bus.mem_ready, (c == LAT + 1));
         end
         total++;
         if (bus.mem_rdata !== last_rdata) begin
            bad++; $display("FAIL st_rdata_hold c%0d: got %h want %h", c, bus.mem_rdata, last_rdata);
         end
      end
      @(posedge clk); #1;
      bus.mem_write   = 1'b0;
      bus.mem_wdata   = 32'h0;
      bus.mem_request = 1'b0;
      @(posedge clk); #1;
      // Read the stored word back through the arbiter.
      bus.mem_request = 1'b1;
      exp_mem_q.push_back(32'hDEAD_BEEF);
      for (int c = 0; c <= LAT + 1; c++) begin
         @(negedge clk);
         total++;
         if (bus.mem_ready !== (c == LAT + 1)) begin
            bad++; $display("FAIL st_rb_ready c%0d: got %b", c, bus.mem_ready);
         end
         if (bus.mem_ready === 1'b1) begin
            total++;
            if (exp_mem_q.size() == 0) begin
               bad++; $display("FAIL st_rb_sb: unexpected mem_ready");
            end else begin
               exp_v = exp_mem_q.pop_front();
               if (bus.mem_rdata !== exp_v) begin
                  bad++; $display("FAIL st_rb_data: got %h want %h", bus.mem_rdata, exp_v);
               end
               last_rdata = exp_v;
            end
         end
      end
      @(posedge clk); #1;
      bus.mem_request = 1'b0;
   endtask

   task automatic test_flush();
      @(posedge clk); #1;
      bus.if_request = 1'b1;
      bus.if_address = 32'h0000_0050;
      for (int c = 0; c <= LAT + 3; c++) begin
         @(negedge clk);
         total++;
         if (bus.ram_enable !== (c >= 1 && c <= LAT)) begin
            bad++; $display("FAIL fl_enable c%0d: got %b want %b", c, bus.ram_enable, (c >= 1 && c <= LAT));
         end
         total++;
         if (bus.if_ready !== 1'b0 || bus.if_instruction !== last_instr) begin
            bad++; $display("FAIL fl_no_ready c%0d: got rdy %b instr %h want 0 %h", c, bus.if_ready, bus.if_instruction, last_instr);
         end
         if (c == LAT + 1) begin
            total++;
            if (dbg_state !== ST_IDLE) begin
               bad++; $display("FAIL fl_idle: got state %0d want 0", dbg_state);
            end
         end
         if (c == 0) begin
            @(posedge clk); #1;
            bus.if_request = 1'b0;
         end
      end
   endtask

   task automatic test_reset_mid_access();
      @(posedge clk); #1;
      bus.mem_request = 1'b1;
      bus.mem_write   = 1'b1;
      bus.mem_address = 32'h0000_0300;
      bus.mem_wdata   = 32'h0BAD_F00D;
      @(posedge clk); #3;
      total++;
      if (bus.ram_enable !== 1'b1 || bus.ram_write !== 1'b1) begin
         bad++; $display("FAIL rm_active: got en %b wr %b want 1 1", bus.ram_enable, bus.ram_write);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if (bus.ram_enable !== 1'b0 || bus.ram_write !== 1'b0 || bus.ram_address !== 32'h0) begin
         bad++; $display("FAIL rm_async: got en %b wr %b addr %h want 0 0 0", bus.ram_enable, bus.ram_write, bus.ram_address);
      end
      total++;
      if (bus.if_instruction !== 32'h0 || bus.mem_rdata !== 32'h0) begin
         bad++; $display("FAIL rm_data_clear: got %h/%h want 0/0", bus.if_instruction, bus.mem_rdata);
      end
      drive_idle();
      last_instr = 32'h0;
      last_rdata = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         total++;
         if (bus.mem_ready !== 1'b0 || bus.ram_enable !== 1'b0) begin
            bad++; $display("FAIL rm_quiet c%0d: got rdy %b en %b", c, bus.mem_ready, bus.ram_enable);
         end
      end
      total++;
      if (ram_mem[8'(32'h300 >> 2)] !== init_word(32'h0000_0300)) begin
         bad++; $display("FAIL rm_no_commit: got %h want %h", ram_mem[8'(32'h300 >> 2)], init_word(32'h0000_0300));
      end
      @(posedge clk); #1;
      bus.mem_request = 1'b1;
      bus.mem_write   = 1'b0;
      bus.mem_address = 32'h0000_0100;
      exp_mem_q.push_back(init_word(32'h0000_0100));
      for (int c = 0; c <= LAT + 1; c++) begin
         @(negedge clk);
         total++;
         if (bus.mem_ready !== (c == LAT + 1)) begin
            bad++; $display("FAIL rm_fresh_ready c%0d: got %b", c, bus.mem_ready);
         end
         if (bus.mem_ready === 1'b1) begin
            total++;
            if (exp_mem_q.size() == 0) begin
               bad++; $display("FAIL rm_sb: unexpected mem_ready");
            end else begin
               exp_v = exp_mem_q.pop_front();
               if (bus.mem_rdata !== exp_v) begin
                  bad++; $display("FAIL rm_fresh_data: got %h want %h", bus.mem_rdata, exp_v);
               end
               last_rdata = exp_v;
            end
         end
      end
      @(posedge clk); #1;
      bus.mem_request = 1'b0;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b1;
      drive_idle();
      test_reset();
      test_single_fetch();
      test_simultaneous();
      test_round_robin();
      test_tie_fetch_first();
      test_store();
      test_flush();
      test_reset_mid_access();
      repeat (2) @(negedge clk);
      total++;
      if (exp_if_q.size() != 0 || exp_mem_q.size() != 0) begin
         bad++; $display("FAIL sb_drain: got %0d/%0d left want 0/0", exp_if_q.size(), exp_mem_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
